// File: rtl/cmd_load_table.sv
// Command-packet table loader: validates a packet header, then streams its
// fixed-width records into one of NUM_TABLES table write ports with backpressure.
module cmd_load_table #(
    parameter int  DEPTH       = 1024,
    parameter int  IDX_W       = 16,
    parameter int  IDX_PER_REC = 3,
    parameter int  NUM_TABLES  = 2,
    parameter int  PACKET_SIZE = 256,
    localparam int AW          = $clog2(DEPTH),
    localparam int DW          = IDX_PER_REC * IDX_W
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     begin_req_pulse,
    input  logic [7:0]               begin_len,
    input  logic [8*PACKET_SIZE-1:0] begin_packet,
    output logic [NUM_TABLES-1:0]    tbl_sel,
    output logic [AW-1:0]            tbl_waddr,
    output logic [DW-1:0]            tbl_wdata,
    output logic                     tbl_we,
    input  logic                     tbl_wready,
    output logic                     BUSY,
    output logic                     done,
    output logic                     err_len,
    output logic                     err_range,
    output logic                     err_proto
);

    localparam int FB = IDX_W / 8;
    localparam int RB = IDX_PER_REC * FB;
    localparam int PW = 8 * PACKET_SIZE;
    localparam logic [NUM_TABLES-1:0] SEL_ONE = NUM_TABLES'(1);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

    state_t        state;
    logic [PW-1:0] pkt_q;
    logic [7:0]    len_q;
    logic [7:0]    cnt_q;
    logic [7:0]    id_q;
    logic [7:0]    rec_q;
    logic [15:0]   start_q;

    logic          accept_req;
    logic          accept_wr;
    logic [15:0]   need_len;
    logic [15:0]   need_pkt;
    logic [16:0]   end_addr;
    logic          chk_len;
    logic          chk_range;
    logic          chk_proto;
    logic          last_rec;

    // Record 0 always sits at byte 6 of pkt_q; the payload shifts down one
    // record per accepted write, so extraction uses constant offsets only.
    function automatic logic [DW-1:0] rec_from(input logic [PW-1:0] pkt);
        logic [DW-1:0] rec;
        rec = '0;
        for (int f = 0; f < IDX_PER_REC; f++) begin
            for (int b = 0; b < FB; b++) begin
                rec[f*IDX_W + (FB-1-b)*8 +: 8] = pkt[(6 + f*FB + b)*8 +: 8];
            end
        end
        return rec;
    endfunction

    assign accept_req = (state == IDLE) && begin_req_pulse;
    assign accept_wr  = (state == WRITE) && tbl_wready;

    assign need_len  = 16'd4 + 16'(cnt_q) * 16'(RB);
    assign need_pkt  = 16'd6 + 16'(cnt_q) * 16'(RB);
    assign end_addr  = {1'b0, start_q} + {9'd0, cnt_q};
    assign chk_len   = ({8'd0, len_q} != need_len) || (need_pkt > 16'(PACKET_SIZE));
    assign chk_range = end_addr > 17'(DEPTH);
    assign chk_proto = ({24'd0, id_q} >= 32'(NUM_TABLES)) || (cnt_q == 8'd0);
    assign last_rec  = rec_q == (cnt_q - 8'd1);

    // NOTE: the payload register is deliberately left out of reset; it is only
    // ever read after a capture has loaded it, and resetting 8*PACKET_SIZE
    // flops would buy nothing.
    always_ff @(posedge CLK) begin
        if (accept_req) begin
            pkt_q <= begin_packet;
        end else if (accept_wr) begin
            pkt_q <= pkt_q >> (RB * 8);
        end
    end

    // NOTE: all state and outputs here update with non-blocking assignments so
    // every branch sees the pre-edge values of state, rec_q and the outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            rec_q     <= '0;
            start_q   <= '0;
            tbl_sel   <= '0;
            tbl_waddr <= '0;
            tbl_wdata <= '0;
            tbl_we    <= 1'b0;
            BUSY      <= 1'b0;
            done      <= 1'b0;
            err_len   <= 1'b0;
            err_range <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (begin_req_pulse) begin
                        len_q     <= begin_len;
                        id_q      <= begin_packet[23:16];
                        cnt_q     <= begin_packet[31:24];
                        start_q   <= {begin_packet[39:32], begin_packet[47:40]};
                        err_len   <= 1'b0;
                        err_range <= 1'b0;
                        err_proto <= 1'b0;
                        BUSY      <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    err_len   <= chk_len;
                    err_range <= chk_range;
                    err_proto <= chk_proto;
                    if (chk_len || chk_range || chk_proto) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rec_q     <= '0;
                        tbl_we    <= 1'b1;
                        tbl_sel   <= SEL_ONE << id_q;
                        tbl_waddr <= start_q[AW-1:0];
                        tbl_wdata <= rec_from(pkt_q);
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    // Without tbl_wready nothing changes, so the write is held.
                    if (tbl_wready) begin
                        if (last_rec) begin
                            tbl_we    <= 1'b0;
                            tbl_sel   <= '0;
                            tbl_waddr <= '0;
                            tbl_wdata <= '0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rec_q     <= rec_q + 8'd1;
                            tbl_waddr <= tbl_waddr + AW'(1);
                            tbl_wdata <= rec_from(pkt_q >> (RB * 8));
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_load_table.sv
// Self-checking bench for cmd_load_table: table-driven vectors, hand-written
// corner sequences and randomized packets checked against a byte-level model.
module tb_cmd_load_table;

    localparam int PS    = 256;
    localparam int RB    = 6;
    localparam int DEPTH = 1024;
    localparam int NT    = 2;

    logic              CLK = 1'b0;
    logic              rst_n;
    logic              begin_req_pulse;
    logic [7:0]        begin_len;
    logic [8*PS-1:0]   begin_packet;
    logic [NT-1:0]     tbl_sel;
    logic [9:0]        tbl_waddr;
    logic [47:0]       tbl_wdata;
    logic              tbl_we;
    logic              tbl_wready;
    logic              BUSY;
    logic              done;
    logic              err_len;
    logic              err_range;
    logic              err_proto;

    always #5 CLK = ~CLK;

    cmd_load_table dut (
        .CLK             (CLK),
        .rst_n           (rst_n),
        .begin_req_pulse (begin_req_pulse),
        .begin_len       (begin_len),
        .begin_packet    (begin_packet),
        .tbl_sel         (tbl_sel),
        .tbl_waddr       (tbl_waddr),
        .tbl_wdata       (tbl_wdata),
        .tbl_we          (tbl_we),
        .tbl_wready      (tbl_wready),
        .BUSY            (BUSY),
        .done            (done),
        .err_len         (err_len),
        .err_range       (err_range),
        .err_proto       (err_proto)
    );

    typedef struct {
        logic [NT-1:0] sel;
        logic [9:0]    addr;
        logic [47:0]   data;
    } wr_t;

    typedef struct {
        int         id;
        int         cnt;
        int         start;
        int         len;
        int         stall;
        logic [2:0] err;   // {len, range, proto}
        int         nwr;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] pb[PS];
    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [2:0] exp_err;
    vec_t       vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic build(input int id, input int cnt, input int start, input bit seq_payload);
        for (int k = 0; k < PS; k++) pb[k] = 8'($urandom);
        pb[2] = 8'(id);
        pb[3] = 8'(cnt);
        pb[4] = 8'(start >> 8);
        pb[5] = 8'(start);
        if (seq_payload) begin
            for (int i = 0; i < 12; i++) pb[6+i] = (i % 2 == 0) ? 8'h00 : 8'(i / 2 + 1);
        end
    endtask

    function automatic logic [8*PS-1:0] pack();
        logic [8*PS-1:0] v;
        for (int k = 0; k < PS; k++) v[8*k +: 8] = pb[k];
        return v;
    endfunction

    // Reference: header rules in plain integer arithmetic, records read as
    // big-endian byte pairs straight from the packet byte array.
    task automatic model(input int len);
        int  id;
        int  cnt;
        int  start;
        int  val;
        wr_t w;
        id    = pb[2];
        cnt   = pb[3];
        start = pb[4] * 256 + pb[5];
        exp_q.delete();
        exp_err[2] = (len != 4 + cnt * RB) || (6 + cnt * RB > PS);
        exp_err[1] = (start + cnt > DEPTH);
        exp_err[0] = (id >= NT) || (cnt == 0);
        if (exp_err == 3'b000) begin
            for (int r = 0; r < cnt; r++) begin
                w.sel  = NT'(1 << id);
                w.addr = 10'(start + r);
                w.data = '0;
                for (int f = 0; f < 3; f++) begin
                    val = pb[6 + r*RB + 2*f] * 256 + pb[7 + r*RB + 2*f];
                    w.data = w.data | (48'(val) << (16 * f));
                end
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic do_txn(input int len, input int stall_first, input bit rnd_stall,
                          input bit pulse_during, output int done_cyc, output int stalls,
                          output logic [2:0] got_err, output int nwr);
        logic [8*PS-1:0] pkt;
        int              first_we;
        bit              prev_stall;
        bit              st;
        logic [NT-1:0]   h_sel;
        logic [9:0]      h_addr;
        logic [47:0]     h_data;
        wr_t             w;
        pkt        = pack();
        model(len);
        got_q.delete();
        stalls     = 0;
        done_cyc   = -1;
        first_we   = -1;
        prev_stall = 1'b0;
        got_err    = 3'b000;
        h_sel      = '0;
        h_addr     = '0;
        h_data     = '0;
        @(negedge CLK);
        begin_req_pulse = 1'b1;
        begin_packet    = pkt;
        begin_len       = 8'(len);
        tbl_wready      = 1'b1;
        @(negedge CLK);
        begin_req_pulse = 1'b0;
        begin_packet    = ~pkt;
        begin_len       = ~begin_len;
        check("busy_after_accept", 64'(BUSY), 64'd1);
        for (int cyc = 1; cyc < 300; cyc++) begin
            if (prev_stall) begin
                check("stall_hold", {tbl_we, tbl_sel, tbl_waddr, tbl_wdata},
                      {1'b1, h_sel, h_addr, h_data});
            end
            if (done) begin
                done_cyc        = cyc;
                got_err         = {err_len, err_range, err_proto};
                begin_req_pulse = 1'b0;
                break;
            end
            if (tbl_we) begin
                if (first_we < 0) first_we = cyc;
                st         = (stalls < stall_first) || (rnd_stall && ($urandom_range(0, 3) == 0));
                tbl_wready = !st;
                if (st) begin
                    stalls++;
                    h_sel  = tbl_sel;
                    h_addr = tbl_waddr;
                    h_data = tbl_wdata;
                end else begin
                    w.sel  = tbl_sel;
                    w.addr = tbl_waddr;
                    w.data = tbl_wdata;
                    got_q.push_back(w);
                end
                prev_stall = st;
                if (pulse_during) begin
                    begin_req_pulse = 1'b1;
                    begin_packet    = pkt ^ {PS{8'h5a}};
                    begin_len       = 8'd16;
                end
            end else begin
                prev_stall = 1'b0;
                tbl_wready = 1'($urandom_range(0, 1));
            end
            @(negedge CLK);
        end
        check("done_seen", 64'(done), 64'd1);
        nwr = got_q.size();
        check("model_err", 64'(got_err), 64'(exp_err));
        check("model_nwr", 64'(nwr), 64'(exp_q.size()));
        check("model_done_cyc", 64'(done_cyc),
              64'((exp_err != 0) ? 2 : 2 + exp_q.size() + stalls));
        check("first_we_cyc", 64'(first_we), 64'((exp_err != 0) ? -1 : 2));
        for (int i = 0; i < nwr && i < exp_q.size(); i++) begin
            check($sformatf("wr%0d_sel", i),  64'(got_q[i].sel),  64'(exp_q[i].sel));
            check($sformatf("wr%0d_addr", i), 64'(got_q[i].addr), 64'(exp_q[i].addr));
            check($sformatf("wr%0d_data", i), 64'(got_q[i].data), 64'(exp_q[i].data));
        end
        @(negedge CLK);
        check("busy_after_done", 64'(BUSY), 64'd0);
        check("done_one_cycle", 64'(done), 64'd0);
        check("err_held", 64'({err_len, err_range, err_proto}), 64'(exp_err));
    endtask

    initial begin
        int         dc;
        int         st;
        int         nw;
        logic [2:0] ge;
        int         id;
        int         cnt;
        int         start;
        int         len;
        vec_t       v;

        rst_n           = 1'b0;
        begin_req_pulse = 1'b0;
        begin_len       = '0;
        begin_packet    = '0;
        tbl_wready      = 1'b1;
        #12;
        check("reset_outputs", {tbl_sel, tbl_waddr, tbl_wdata, tbl_we, BUSY, done,
                                err_len, err_range, err_proto}, 64'd0);
        @(negedge CLK);
        rst_n = 1'b1;

        // Exact reference packet: stalled for three cycles on the first write.
        build(1, 2, 16'h0010, 1'b1);
        do_txn(16, 3, 1'b0, 1'b0, dc, st, ge, nw);
        check("tp_done_cyc", 64'(dc), 64'd7);
        check("tp_nwr", 64'(nw), 64'd2);
        if (nw >= 2) begin
            check("tp_sel0",  64'(got_q[0].sel),  64'h2);
            check("tp_addr0", 64'(got_q[0].addr), 64'h010);
            check("tp_data0", 64'(got_q[0].data), 64'h0003_0002_0001);
            check("tp_addr1", 64'(got_q[1].addr), 64'h011);
            check("tp_data1", 64'(got_q[1].data), 64'h0006_0005_0004);
        end

        vecs.push_back('{1,  2, 16'h0010, 16,  0, 3'b000,  2});
        vecs.push_back('{0,  1, 16'h03FF, 10,  0, 3'b000,  1});
        vecs.push_back('{0,  2, 16'h03FF, 16,  0, 3'b010,  0});
        vecs.push_back('{1,  2, 16'h0010, 16,  0, 3'b000,  2});
        vecs.push_back('{1,  2, 16'h0000, 15,  0, 3'b100,  0});
        vecs.push_back('{0,  1, 16'h0005, 10,  0, 3'b000,  1});
        vecs.push_back('{2,  1, 16'h0000, 10,  0, 3'b001,  0});
        vecs.push_back('{1,  3, 16'h0200, 22,  1, 3'b000,  3});
        vecs.push_back('{0,  0, 16'h0000,  4,  0, 3'b001,  0});
        vecs.push_back('{0, 42, 16'h0000,  0,  0, 3'b100,  0});
        vecs.push_back('{1, 41, 16'h0100, 250, 2, 3'b000, 41});
        vecs.push_back('{3,  2, 16'h03FF, 15,  0, 3'b111,  0});
        vecs.push_back('{0,  1, 16'hFFFF, 10,  0, 3'b010,  0});
        vecs.push_back('{0,  1, 16'h0000, 10,  0, 3'b000,  1});
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            build(v.id, v.cnt, v.start, 1'b0);
            do_txn(v.len, v.stall, 1'b0, 1'b0, dc, st, ge, nw);
            check($sformatf("vec%0d_err", i), 64'(ge), 64'(v.err));
            check($sformatf("vec%0d_nwr", i), 64'(nw), 64'(v.nwr));
            check($sformatf("vec%0d_done", i), 64'(dc),
                  64'((v.err != 0) ? 2 : 2 + v.nwr + st));
        end

        // Reset in the middle of a three-record load, after one write.
        build(0, 3, 16'h0020, 1'b0);
        @(negedge CLK);
        begin_req_pulse = 1'b1;
        begin_packet    = pack();
        begin_len       = 8'd22;
        tbl_wready      = 1'b1;
        @(negedge CLK);
        begin_req_pulse = 1'b0;
        @(negedge CLK);
        check("rst_seq_we0", 64'({tbl_we, tbl_waddr}), {53'd0, 1'b1, 10'h020});
        @(negedge CLK);
        check("rst_seq_we1", 64'({tbl_we, tbl_waddr}), {53'd0, 1'b1, 10'h021});
        rst_n = 1'b0;
        #1;
        check("rst_mid_write", {tbl_sel, tbl_waddr, tbl_wdata, tbl_we, BUSY, done,
                                err_len, err_range, err_proto}, 64'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        build(1, 2, 16'h0030, 1'b0);
        do_txn(16, 0, 1'b0, 1'b0, dc, st, ge, nw);
        check("after_rst_nwr", 64'(nw), 64'd2);

        // Request strobes during WRITE must be dropped.
        build(0, 3, 16'h0100, 1'b0);
        do_txn(22, 1, 1'b0, 1'b1, dc, st, ge, nw);
        check("pulse_in_write_nwr", 64'(nw), 64'd3);

        for (int n = 0; n < 30; n++) begin
            id    = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
            cnt   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            start = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1016, 1023))
                                                : int'($urandom_range(0, 1023));
            len   = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 60)) : 4 + cnt * RB;
            build(id, cnt, start, 1'b0);
            do_txn(len, 0, 1'b1, 1'($urandom_range(0, 1)), dc, st, ge, nw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
